// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcode/funct, ALU code, mux code and state definitions for the MIPS control units
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_MUL = 6'b011100;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b101;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [1:0] {
      AOP_ADD,
      AOP_SUB,
      AOP_FUNCT,
      AOP_MUL
   } alu_op_t;

   typedef enum logic [3:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_MULWAIT,
      S_ALUWB,
      S_ADDI_EX,
      S_ADDI_WB,
      S_BRANCH,
      S_JUMP
   } state_t;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: maps the FSM's ALU request plus the R-type funct field onto an ALU control code
module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W  = 3,
   parameter bit ENABLE_MUL = 1'b1
) (
   input  logic [5:0]           funct,
   input  alu_op_t              alu_op,
   output logic [ALUCTRL_W-1:0] alu_control
);

   logic [2:0] code;

   // fixed ops from the FSM win; otherwise funct selects, with unknown functs (and mul when absent) falling back to add
   always_comb begin
      code = (alu_op == AOP_SUB)                  ? ALU_SUB :
             (alu_op == AOP_MUL)                  ? ALU_MUL :
             (alu_op == AOP_ADD)                  ? ALU_ADD :
             (funct == FN_SUB)                    ? ALU_SUB :
             (funct == FN_SLT)                    ? ALU_SLT :
             (ENABLE_MUL && funct == FN_MUL)      ? ALU_MUL :
                                                    ALU_ADD;
   end

   assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS control FSM driving the shared-ALU/shared-memory datapath
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int ALUCTRL_W  = 3,
   parameter bit ENABLE_MUL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 mem_ready,
   input  logic                 zero,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 iord,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 mem_to_reg,
   output logic                 reg_dst,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           pc_src,
   output logic [ALUCTRL_W-1:0] alu_control,
   output logic                 illegal_instr
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   state_t     state, next;
   logic [3:0] cnt, cnt_next;
   alu_op_t    alu_op;
   logic [5:0] opcode, funct;
   logic       mul_op;
   logic       unused_bits;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign mul_op = ENABLE_MUL && (funct == FN_MUL) && (MUL_CYCLES > 1);

   // zero is consumed by the datapath together with pc_write_cond; the remaining instruction fields belong to it too
   assign unused_bits = ^{zero, instr[25:6]};

   // state and mul counter register; reset aborts any instruction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_RST;
         cnt   <= '0;
      end else begin
         state <= next;
         cnt   <= cnt_next;
      end
   end

   // next-state and per-state datapath control decode
   always_comb begin
      next          = state;
      cnt_next      = cnt;
      alu_op        = AOP_ADD;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      pc_src        = PC_ALU;
      illegal_instr = 1'b0;
      case (state)
         S_RST: next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            next      = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMMSH;
            case (opcode)
               OP_LW, OP_SW: next = S_MEMADR;
               OP_RTYPE:     next = S_EXEC;
               OP_ADDI:      next = S_ADDI_EX;
               OP_BEQ:       next = S_BRANCH;
               OP_J:         next = S_JUMP;
               default: begin
                  illegal_instr = 1'b1;
                  next          = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            next      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            next     = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            next       = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            next      = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = AOP_FUNCT;
            cnt_next  = MUL_LOAD;
            next      = mul_op ? S_MULWAIT : S_ALUWB;
         end
         S_MULWAIT: begin
            alu_src_a = 1'b1;
            alu_op    = AOP_MUL;
            cnt_next  = cnt - 4'd1;
            next      = (cnt <= 4'd1) ? S_ALUWB : S_MULWAIT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            next      = S_FETCH;
         end
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            next      = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            next      = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = AOP_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PC_ALUOUT;
            next          = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            next     = S_FETCH;
         end
         default: next = S_FETCH;
      endcase
   end

   alu_decoder #(
      .ALUCTRL_W (ALUCTRL_W),
      .ENABLE_MUL(ENABLE_MUL)
   ) u_alu_decoder (
      .funct      (funct),
      .alu_op     (alu_op),
      .alu_control(alu_control)
   );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven cycle-by-cycle check of the multicycle control FSM outputs
module tb_multicycle_control_unit;

   typedef struct {
      logic        rdy;
      logic        z;
      logic [31:0] ins;
      logic [17:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst0 = 1'b1;
   logic [31:0] instr = 32'h8C080004;
   logic        mem_ready = 1'b1;
   logic        zero = 1'b0;

   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_instr;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;

   logic       pc_write0, pc_write_cond0, iord0, mem_read0, mem_write0, ir_write0;
   logic       mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, illegal_instr0;
   logic [1:0] alu_src_b0, pc_src0;
   logic [2:0] alu_control0;

   logic [17:0] got, got0;
   int total = 0;
   int bad = 0;
   vec_t vq[$];

   logic [17:0] p_rst, p_fw, p_fg, p_dec, p_ill, p_madr, p_mrd, p_mwb, p_mwr;
   logic [17:0] p_add, p_sub, p_slt, p_mul, p_awb, p_aex, p_iwb, p_br, p_j;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MUL_CYCLES(4), .ALUCTRL_W(3), .ENABLE_MUL(1'b1)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .illegal_instr(illegal_instr)
   );

   multicycle_control_unit #(.MUL_CYCLES(4), .ALUCTRL_W(3), .ENABLE_MUL(1'b0)) dut0 (
      .clk(clk), .rst(rst0), .instr(instr), .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .iord(iord0),
      .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
      .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .reg_write(reg_write0),
      .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .pc_src(pc_src0),
      .alu_control(alu_control0), .illegal_instr(illegal_instr0)
   );

   assign got  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_control, illegal_instr};
   assign got0 = {pc_write0, pc_write_cond0, iord0, mem_read0, mem_write0, ir_write0, mem_to_reg0,
                  reg_dst0, reg_write0, alu_src_a0, alu_src_b0, pc_src0, alu_control0, illegal_instr0};

   function automatic logic [17:0] mk(input logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa,
                                      input logic [1:0] asb, pcs, input logic [2:0] alu,
                                      input logic ill);
      return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, alu, ill};
   endfunction

   task automatic chk(input string name, input logic [17:0] g, input logic [17:0] e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s got=%b exp=%b (pw pwc iord mr mw irw m2r rdst rw asa asb pcs alu ill)",
                  name, g, e);
      end
   endtask

   task automatic add(input logic rdy, input logic z, input logic [31:0] ins, input logic [17:0] exp);
      vq.push_back('{rdy, z, ins, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      p_rst  = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
      p_fw   = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
      p_fg   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b010,0);
      p_dec  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
      p_ill  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
      p_madr = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
      p_mrd  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
      p_mwb  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0);
      p_mwr  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b010,0);
      p_add  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0);
      p_sub  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b100,0);
      p_slt  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0);
      p_mul  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b101,0);
      p_awb  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,0);
      p_aex  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
      p_iwb  = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0);
      p_br   = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b100,0);
      p_j    = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0);

      // lw straight through: reset-exit cycle then FETCH..MEMWB
      add(1,0,32'h8C080004,p_rst);
      add(1,0,32'h8C080004,p_fg);
      add(1,0,32'h8C080004,p_dec);
      add(1,0,32'h8C080004,p_madr);
      add(1,0,32'h8C080004,p_mrd);
      add(1,0,32'h8C080004,p_mwb);
      // R-type add, unknown funct, sub, slt
      add(1,0,32'h01095020,p_fg);  add(1,0,32'h01095020,p_dec);
      add(1,0,32'h01095020,p_add); add(1,0,32'h01095020,p_awb);
      add(1,0,32'h0109503F,p_fg);  add(1,0,32'h0109503F,p_dec);
      add(1,0,32'h0109503F,p_add); add(1,0,32'h0109503F,p_awb);
      add(1,0,32'h01095022,p_fg);  add(1,0,32'h01095022,p_dec);
      add(1,0,32'h01095022,p_sub); add(1,0,32'h01095022,p_awb);
      add(1,0,32'h0109502A,p_fg);  add(1,0,32'h0109502A,p_dec);
      add(1,0,32'h0109502A,p_slt); add(1,0,32'h0109502A,p_awb);
      // mul: EXEC + 3 MULWAIT at 101, ALUWB on clock 7
      add(1,0,32'h0109501C,p_fg);  add(1,0,32'h0109501C,p_dec);
      add(1,0,32'h0109501C,p_mul); add(1,0,32'h0109501C,p_mul);
      add(1,0,32'h0109501C,p_mul); add(1,0,32'h0109501C,p_mul);
      add(1,0,32'h0109501C,p_awb);
      // sw with 3 not-ready cycles in MEMWR
      add(1,0,32'hAC080004,p_fg);  add(1,0,32'hAC080004,p_dec);
      add(1,0,32'hAC080004,p_madr);
      add(0,0,32'hAC080004,p_mwr); add(0,0,32'hAC080004,p_mwr);
      add(0,0,32'hAC080004,p_mwr); add(1,0,32'hAC080004,p_mwr);
      // FETCH stalls with garbage on instr, then beq taken
      add(0,1,32'hFFFFFFFF,p_fw);  add(0,1,32'hFFFFFFFF,p_fw);
      add(1,1,32'h11090003,p_fg);  add(1,1,32'h11090003,p_dec);
      add(1,1,32'h11090003,p_br);
      // jump
      add(1,0,32'h08000010,p_fg);  add(1,0,32'h08000010,p_dec);
      add(1,0,32'h08000010,p_j);
      // illegal opcode pulses once, then straight back to FETCH
      add(1,0,32'hFC000000,p_fg);  add(1,0,32'hFC000000,p_ill);
      add(1,0,32'h21080005,p_fg);
      // addi
      add(1,0,32'h21080005,p_dec); add(1,0,32'h21080005,p_aex);
      add(1,0,32'h21080005,p_iwb);
      // lw with one read wait
      add(1,0,32'h8C080004,p_fg);  add(1,0,32'h8C080004,p_dec);
      add(1,0,32'h8C080004,p_madr);
      add(0,0,32'h8C080004,p_mrd); add(1,0,32'h8C080004,p_mrd);
      add(1,0,32'h8C080004,p_mwb);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("reset%0d", i), got, p_rst);
         chk($sformatf("reset_nomul%0d", i), got0, p_rst);
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         mem_ready = vq[i].rdy;
         zero      = vq[i].z;
         instr     = vq[i].ins;
         @(negedge clk);
         chk($sformatf("vec%0d", i), got, vq[i].exp);
         total++;
         if (mem_read && mem_write) begin
            bad++;
            $display("FAIL rw_excl vec%0d got mem_read=1 mem_write=1 exp not both", i);
         end
         tick();
      end

      // reset in the middle of MULWAIT drops outputs without a clock
      mem_ready = 1'b1;
      instr     = 32'h0109501C;
      @(negedge clk); chk("mw_fetch", got, p_fg);  tick();
      @(negedge clk); chk("mw_dec", got, p_dec);   tick();
      @(negedge clk); chk("mw_exec", got, p_mul);  tick();
      @(negedge clk); chk("mw_wait", got, p_mul);  tick();
      rst = 1'b1;
      #1;
      chk("mw_async_rst", got, p_rst);
      tick();
      rst = 1'b0;
      @(negedge clk); chk("mw_rst_exit", got, p_rst); tick();
      @(negedge clk); chk("mw_refetch", got, p_fg);   tick();

      // mul without the multiplier: single-cycle add
      rst0 = 1'b0;
      @(negedge clk); chk("nomul_rst", got0, p_rst);   tick();
      @(negedge clk); chk("nomul_fetch", got0, p_fg);  tick();
      @(negedge clk); chk("nomul_dec", got0, p_dec);   tick();
      @(negedge clk); chk("nomul_exec", got0, p_add);  tick();
      @(negedge clk); chk("nomul_wb", got0, p_awb);    tick();
      @(negedge clk); chk("nomul_next", got0, p_fg);   tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
